// File: rtl/alu_result_collector_if.sv
// Result-path handshake bundle: producer-to-collector push side and collector-to-writeback side.
// The collector takes the slave modport; the producer/writeback model takes master.
interface alu_result_collector_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_result;
   logic [2:0]            in_nzp;
   logic [REG_ADDR_W-1:0] in_dest;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [DATA_W-1:0]     wb_data;
   logic [REG_ADDR_W-1:0] wb_addr;

   modport master (
      output in_valid, in_result, in_nzp, in_dest, wb_ready,
      input  in_ready, wb_valid, wb_data, wb_addr
   );

   modport slave (
      input  in_valid, in_result, in_nzp, in_dest, wb_ready,
      output in_ready, wb_valid, wb_data, wb_addr
   );
endinterface

// File: rtl/alu_result_collector.sv
// ALU result collector: in-order FIFO from ALU results to register writeback, latching nzp on retire.
// Optional ALU_COLLECT_STATS_EN adds a 16-bit wrapping retire_count output.
module alu_result_collector #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_result_collector_if.slave      bus,
   output logic [2:0]                 cc_nzp,
   output logic [$clog2(DEPTH):0]     occupancy,
`ifdef ALU_COLLECT_STATS_EN
   output logic [15:0]                retire_count,
`endif
   output logic                       nzp_err
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_W-1:0]     mem_result_q [DEPTH];
   logic [2:0]            mem_nzp_q    [DEPTH];
   logic [REG_ADDR_W-1:0] mem_dest_q   [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] occ_q, occ_d;
   logic [2:0]      cc_nzp_q, cc_nzp_d;
   logic            nzp_err_q, nzp_err_d;
   logic            push, pop, nzp_onehot;
`ifdef ALU_COLLECT_STATS_EN
   logic [15:0]     retire_cnt_q, retire_cnt_d;
`endif

   always_comb begin
      bus.in_ready = occ_q < CntW'(DEPTH);
      bus.wb_valid = occ_q != '0;
      bus.wb_data  = mem_result_q[rd_ptr_q];
      bus.wb_addr  = mem_dest_q[rd_ptr_q];
      push         = bus.in_valid && bus.in_ready;
      pop          = bus.wb_valid && bus.wb_ready;
      nzp_onehot   = (bus.in_nzp == 3'b001) || (bus.in_nzp == 3'b010) || (bus.in_nzp == 3'b100);
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      cc_nzp_d  = cc_nzp_q;
      nzp_err_d = nzp_err_q;
`ifdef ALU_COLLECT_STATS_EN
      retire_cnt_d = retire_cnt_q;
`endif
      // Pointers are PtrW bits wide, so increment wraps modulo DEPTH for free.
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (!nzp_onehot) nzp_err_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         cc_nzp_d = mem_nzp_q[rd_ptr_q];
`ifdef ALU_COLLECT_STATS_EN
         retire_cnt_d = retire_cnt_q + 16'd1;
`endif
      end
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (pop && !push) occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         cc_nzp_q  <= 3'b010;
         nzp_err_q <= 1'b0;
`ifdef ALU_COLLECT_STATS_EN
         retire_cnt_q <= '0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         cc_nzp_q  <= cc_nzp_d;
         nzp_err_q <= nzp_err_d;
`ifdef ALU_COLLECT_STATS_EN
         retire_cnt_q <= retire_cnt_d;
`endif
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_result_q[wr_ptr_q] <= bus.in_result;
         mem_nzp_q[wr_ptr_q]    <= bus.in_nzp;
         mem_dest_q[wr_ptr_q]   <= bus.in_dest;
      end
   end

   assign cc_nzp    = cc_nzp_q;
   assign occupancy = occ_q;
   assign nzp_err   = nzp_err_q;
`ifdef ALU_COLLECT_STATS_EN
   assign retire_count = retire_cnt_q;
`endif
endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector (DEPTH=4).
// With ALU_COLLECT_STATS_EN defined it also checks the 16-bit retire counter wrap.
module tb_alu_result_collector;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] cc_nzp;
   logic [2:0] occupancy;
   logic       nzp_err;
`ifdef ALU_COLLECT_STATS_EN
   logic [15:0] retire_count;
`endif
   int total = 0;
   int bad   = 0;

   alu_result_collector_if #(.DATA_W(32), .REG_ADDR_W(4)) bus ();

   alu_result_collector #(.DATA_W(32), .DEPTH(4), .REG_ADDR_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .cc_nzp       (cc_nzp),
      .occupancy    (occupancy),
`ifdef ALU_COLLECT_STATS_EN
      .retire_count (retire_count),
`endif
      .nzp_err      (nzp_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [2:0] nzp,
                        input logic [3:0] dest);
      bus.in_valid  = v;
      bus.in_result = res;
      bus.in_nzp    = nzp;
      bus.in_dest   = dest;
   endtask

   initial begin
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      bus.wb_ready = 1'b0;
      #12 rst = 1'b0;
      step();
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      check_eq("rst_occ", 32'(occupancy), 32'd0);
      check_eq("rst_cc", 32'(cc_nzp), 32'b010);
      check_eq("rst_err", 32'(nzp_err), 32'd0);
`ifdef ALU_COLLECT_STATS_EN
      check_eq("rst_retire", 32'(retire_count), 32'd0);
`endif

      // Single entry
      drive(1'b1, 32'd5, 3'b001, 4'd3);
      bus.wb_ready = 1'b1;
      step();
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      check_eq("single_wb_valid", 32'(bus.wb_valid), 32'd1);
      check_eq("single_wb_data", bus.wb_data, 32'd5);
      check_eq("single_wb_addr", 32'(bus.wb_addr), 32'd3);
      check_eq("single_occ1", 32'(occupancy), 32'd1);
      step();
      check_eq("single_cc", 32'(cc_nzp), 32'b001);
      check_eq("single_occ0", 32'(occupancy), 32'd0);
      check_eq("single_wb_valid0", 32'(bus.wb_valid), 32'd0);

      // Fill and backpressure
      bus.wb_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 32'(i), 3'b010, 4'(i));
         step();
      end
      check_eq("fill_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("fill_occ", 32'(occupancy), 32'd4);
      drive(1'b1, 32'd99, 3'b010, 4'd9);
      step();
      check_eq("fill_fifth_rejected", 32'(occupancy), 32'd4);
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      bus.wb_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check_eq("drain_valid", 32'(bus.wb_valid), 32'd1);
         check_eq("drain_data", bus.wb_data, 32'(i));
         check_eq("drain_addr", 32'(bus.wb_addr), 32'(i));
         step();
      end
      check_eq("drain_occ0", 32'(occupancy), 32'd0);

      // Streaming: one push and one pop per cycle
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 32'(k), 3'b100, 4'(k));
         step();
         check_eq("stream_occ", 32'(occupancy), 32'd1);
         check_eq("stream_data", bus.wb_data, 32'(k));
      end
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      step();
      check_eq("stream_occ0", 32'(occupancy), 32'd0);

      // Flag error
      bus.wb_ready = 1'b0;
      drive(1'b1, 32'd7, 3'b000, 4'd1);
      step();
      drive(1'b1, 32'd8, 3'b100, 4'd2);
      step();
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      check_eq("flag_err_set", 32'(nzp_err), 32'd1);
      bus.wb_ready = 1'b1;
      step();
      check_eq("flag_cc_raw", 32'(cc_nzp), 32'b000);
      check_eq("flag_second_head", bus.wb_data, 32'd8);
      step();
      check_eq("flag_cc_final", 32'(cc_nzp), 32'b100);
      check_eq("flag_err_sticky", 32'(nzp_err), 32'd1);
      check_eq("flag_occ0", 32'(occupancy), 32'd0);

      // Reset mid-operation
      bus.wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(20 + i), 3'b001, 4'(i));
         step();
      end
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      check_eq("mid_occ3", 32'(occupancy), 32'd3);
      #3 rst = 1'b1;
      #1;
      check_eq("mid_wb_valid", 32'(bus.wb_valid), 32'd0);
      check_eq("mid_occ", 32'(occupancy), 32'd0);
      check_eq("mid_cc", 32'(cc_nzp), 32'b010);
      check_eq("mid_err", 32'(nzp_err), 32'd0);
      check_eq("mid_in_ready", 32'(bus.in_ready), 32'd1);
      #1 rst = 1'b0;
      step();
      drive(1'b1, 32'd9, 3'b010, 4'd5);
      step();
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      check_eq("post_rst_data", bus.wb_data, 32'd9);
      check_eq("post_rst_addr", 32'(bus.wb_addr), 32'd5);
      check_eq("post_rst_occ", 32'(occupancy), 32'd1);
      bus.wb_ready = 1'b1;
      step();
      check_eq("post_rst_empty", 32'(bus.wb_valid), 32'd0);

`ifdef ALU_COLLECT_STATS_EN
      // One pop since reset; 65536 more brings the counter round to 1.
      check_eq("stats_one", 32'(retire_count), 32'd1);
      for (int k = 0; k < 65536; k++) begin
         drive(1'b1, 32'(k), 3'b010, 4'd0);
         step();
      end
      drive(1'b0, 32'd0, 3'b010, 4'd0);
      step();
      check_eq("stats_wrap", 32'(retire_count), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Consumer end of the shader-core ALU result path. Accepts ALU results (result word, `nzp` flags, destination register) over a valid/ready handshake. Buffers them in a small FIFO, then drains them in order to the register-file writeback port. As each result retires it latches its `nzp` as the current condition code, for branch evaluation.

## Interface

Parameters:
- `DATA_W`, 32: width of result word, matches ALU `result`.
- `DEPTH`, 4: FIFO entries. Must be a power of two and at least 2.
- `REG_ADDR_W`, 4: destination register address width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer presents a result this cycle.
- `in_ready`  out  1  collector can accept a result this cycle.
- `in_result`  in  DATA_W  ALU result word.
- `in_nzp`  in  3  ALU flags {n,z,p}; expected one-hot.
- `in_dest`  in  REG_ADDR_W  destination register.
- `wb_valid`  out  1  head entry presented to writeback.
- `wb_ready`  in  1  writeback accepts head this cycle.
- `wb_data`  out  DATA_W  head result word.
- `wb_addr`  out  REG_ADDR_W  head destination register.
- `cc_nzp`  out  3  condition code of the most recently retired result.
- `occupancy`  out  $clog2(DEPTH)+1  entries currently held.
- `nzp_err`  out  1  sticky: a pushed entry carried non-one-hot `nzp`.
- `retire_count`  out  16  retired-entry counter. Present only with `ALU_COLLECT_STATS_EN`.

## Operation

- **Push:** fires when `in_valid && in_ready`. Writes {`in_result`, `in_nzp`, `in_dest`} at the write pointer.
- **`in_ready`:** combinational, equals `occupancy < DEPTH`.
  - When full, `in_ready` is 0 even if a pop occurs the same cycle. There is no full-throughput pass-through.
- **Writeback outputs:** `wb_valid = (occupancy != 0)`. `wb_data` and `wb_addr` always reflect the head entry. They are don't-care when `wb_valid` is 0.
- **Pop:** fires when `wb_valid && wb_ready`. Advances the read pointer. `cc_nzp` takes the head entry's `nzp` on the same edge.
- **Pointers:** read and write pointers wrap modulo `DEPTH`.
- **Occupancy update:**
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- **Ordering:** strict FIFO. No reordering and no drops.
- **`nzp_err`:** set on any push whose `in_nzp` is not exactly one-hot (includes 3'b000). Cleared only by `rst`. The offending entry is still stored and retired normally, and its raw `nzp` is copied into `cc_nzp`.
- **Reset values:**
  - `in_ready`=1
  - `wb_valid`=0
  - `occupancy`=0
  - `cc_nzp`=3'b010 (zero)
  - `nzp_err`=0
  - `retire_count`=0
  - both pointers = 0
- **Reset during operation:** asserting `rst` takes effect immediately and asynchronously. All buffered entries are discarded and every output returns to its reset value. The first push after reset release writes entry 0.

## Timing

- Minimum latency is 1 cycle. A push at edge N gives `wb_valid`=1 with that entry during cycle N+1. There is no combinational bypass from `in_*` to `wb_*`.
- `cc_nzp`, `occupancy`, `nzp_err` and `retire_count` are registered. They reflect a push or pop during the cycle after the edge at which it fires.
- `in_ready` depends only on registered occupancy. It has no combinational path from `wb_ready`.
- Sustained throughput is 1 entry per cycle while 0 < `occupancy` < `DEPTH` and both sides stay active.

## Configuration

- Macro `ALU_COLLECT_STATS_EN`.
- **Defined:** the `retire_count` port exists.
  - 16-bit counter, incremented on every pop.
  - Wraps from 16'hFFFF to 16'h0000.
  - Reset to 0 by `rst`.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan

- **Single entry:** reset, then push {result=32'd5, nzp=3'b001, dest=3} with `wb_ready`=1.
  - Next cycle: `wb_valid`=1, `wb_data`=5, `wb_addr`=3.
  - Cycle after the pop: `cc_nzp`=3'b001, `occupancy`=0.
- **Fill and backpressure:** with `DEPTH`=4 and `wb_ready`=0, push results 1,2,3,4.
  - `in_ready` drops to 0 with `occupancy`=4.
  - A fifth `in_valid` is not accepted.
  - Raising `wb_ready` drains 1,2,3,4 in order.
- **Streaming:** push and pop together every cycle for 20 cycles with results 0..19.
  - `occupancy` stays at 1.
  - Outputs appear in order 0..19, each one cycle after its push.
  - Pointers wrap correctly.
- **Flag error:** push an entry with nzp=3'b000, then one with nzp=3'b100.
  - `nzp_err`=1 and stays 1.
  - Both entries retire.
  - `cc_nzp` ends at 3'b100.
- **Reset mid-operation:** with 3 entries buffered, pulse `rst` asynchronously between edges.
  - Immediately: `wb_valid`=0, `occupancy`=0, `cc_nzp`=3'b010.
  - The next push of 32'd9 emerges as the sole entry.
- **Stats wrap (`ALU_COLLECT_STATS_EN` defined):** 65,537 pops give `retire_count`=1.
